// File: rtl/song_sequencer.sv
// Step sequencer for a three-voice song player: walks a shared step address
// at a programmable tempo and gates each voice after a short articulation gap.
module song_sequencer #(
  parameter int unsigned GAP_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_play,
  input  logic        cmd_pause,
  input  logic        cmd_stop,
  input  logic        loop_en,
  input  logic [15:0] tempo_div,
  input  logic [9:0]  song_last,
  input  logic [2:0]  mute,
  output logic [9:0]  addr,
  output logic [2:0]  voice_en,
  output logic        tick,
  output logic        done,
  output logic [1:0]  state
);

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned ADDR_W = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t           st;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] d_len;
  logic [DIV_W-1:0] tempo_eff;
  logic             step_end;
  logic             gate_open;
  logic             at_last;
  logic             play_only;

  // A zero tempo still yields a one-clock step.
  assign tempo_eff = (tempo_div == '0) ? DIV_W'(1) : tempo_div;
  assign step_end  = (div_cnt == d_len - DIV_W'(1));
  assign at_last   = (addr == song_last);
  // cmd_play only acts when no higher-priority command is present.
  assign play_only = cmd_play & ~cmd_pause & ~cmd_stop;
  assign gate_open = (32'(div_cnt) >= GAP_CYC);

  assign state    = st;
  assign voice_en = ((st == S_PLAY) && gate_open) ? ~mute : 3'b000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= S_IDLE;
      addr    <= '0;
      div_cnt <= '0;
      d_len   <= DIV_W'(1);
      tick    <= 1'b0;
      done    <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      unique case (st)
        S_IDLE: begin
          if (play_only) begin
            st      <= S_PLAY;
            addr    <= '0;
            div_cnt <= '0;
            d_len   <= tempo_eff;
          end
        end
        S_PLAY: begin
          if (cmd_stop) begin
            st      <= S_IDLE;
            addr    <= '0;
            div_cnt <= '0;
          end else if (cmd_pause) begin
            st <= S_PAUSE;
          end else if (step_end) begin
            // Step boundary: the new tempo takes effect only here.
            div_cnt <= '0;
            d_len   <= tempo_eff;
            if (!at_last) begin
              addr <= addr + ADDR_W'(1);
              tick <= 1'b1;
            end else if (loop_en) begin
              addr <= '0;
              tick <= 1'b1;
            end else begin
              st   <= S_DONE;
              done <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        S_PAUSE: begin
          if (cmd_stop) begin
            st      <= S_IDLE;
            addr    <= '0;
            div_cnt <= '0;
          end else if (play_only) begin
            st <= S_PLAY;
          end
        end
        S_DONE: begin
          if (cmd_stop) begin
            st      <= S_IDLE;
            addr    <= '0;
            div_cnt <= '0;
          end else if (play_only) begin
            st      <= S_PLAY;
            addr    <= '0;
            div_cnt <= '0;
            d_len   <= tempo_eff;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: directed scenarios plus a random
// command stream compared against a step-level reference model.
module tb_song_sequencer;

  localparam int GAP = 16;

  logic        clk;
  logic        rst;
  logic        cmd_play;
  logic        cmd_pause;
  logic        cmd_stop;
  logic        loop_en;
  logic [15:0] tempo_div;
  logic [9:0]  song_last;
  logic [2:0]  mute;
  logic [9:0]  addr;
  logic [2:0]  voice_en;
  logic        tick;
  logic        done;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 playing, 2 paused, 3 finished.
  int m_mode, m_addr, m_pos, m_len;
  bit m_tick, m_done;

  song_sequencer #(.GAP_CYC(GAP)) dut (
    .clk(clk), .rst(rst), .cmd_play(cmd_play), .cmd_pause(cmd_pause),
    .cmd_stop(cmd_stop), .loop_en(loop_en), .tempo_div(tempo_div),
    .song_last(song_last), .mute(mute), .addr(addr), .voice_en(voice_en),
    .tick(tick), .done(done), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  function automatic int eff_tempo();
    return (tempo_div == 16'd0) ? 1 : int'(tempo_div);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_addr = 0; m_pos = 0; m_len = 1; m_tick = 0; m_done = 0;
  endtask

  task automatic model_step();
    m_tick = 0;
    m_done = 0;
    if (cmd_stop) begin
      m_mode = 0; m_addr = 0; m_pos = 0;
    end else if (cmd_pause) begin
      if (m_mode == 1) m_mode = 2;
    end else if (cmd_play && (m_mode == 0 || m_mode == 3)) begin
      m_mode = 1; m_addr = 0; m_pos = 0; m_len = eff_tempo();
    end else if (cmd_play && m_mode == 2) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      m_pos++;
      if (m_pos >= m_len) begin
        m_pos = 0;
        m_len = eff_tempo();
        if (m_addr != int'(song_last)) begin
          m_addr++; m_tick = 1;
        end else if (loop_en) begin
          m_addr = 0; m_tick = 1;
        end else begin
          m_mode = 3; m_done = 1;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    cmd_play = 0; cmd_pause = 0; cmd_stop = 0;
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic start_play();
    cmd_play = 1;
    cyc();
    cmd_play = 0;
  endtask

  task automatic test_reset();
    rst = 1; cmd_play = 0; cmd_pause = 0; cmd_stop = 0;
    loop_en = 0; tempo_div = 16'd4; song_last = 10'd2; mute = 3'b000;
    model_reset();
    #12;
    checks++;
    if (state !== 2'b00 || addr !== 10'd0 || tick !== 1'b0 || done !== 1'b0 || voice_en !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: state=%b addr=%0d tick=%b done=%b voice=%b, want 00/0/0/0/000",
               state, addr, tick, done, voice_en);
    end
    @(posedge clk); #1; rst = 0;
  endtask

  task automatic test_basic_play();
    logic [9:0] ea;
    do_reset();
    tempo_div = 16'd4; song_last = 10'd2; loop_en = 0; mute = 3'b000;
    start_play();
    checks++;
    if (state !== 2'b01 || addr !== 10'd0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL basic_start: state=%b addr=%0d tick=%b, want 01/0/0", state, addr, tick);
    end
    for (int k = 1; k <= 14; k++) begin
      cyc();
      ea = (k < 4) ? 10'd0 : (k < 8) ? 10'd1 : 10'd2;
      checks++;
      if (tick !== (k == 4 || k == 8) || done !== (k == 12) || addr !== ea ||
          state !== ((k < 12) ? 2'b01 : 2'b11)) begin
        errors++;
        $display("FAIL basic_play clk %0d: tick=%b done=%b addr=%0d state=%b, want tick=%b done=%b addr=%0d",
                 k, tick, done, addr, state, (k == 4 || k == 8), (k == 12), ea);
      end
    end
  endtask

  task automatic test_loop();
    logic [9:0] ea;
    do_reset();
    tempo_div = 16'd4; song_last = 10'd2; loop_en = 1; mute = 3'b000;
    start_play();
    for (int k = 1; k <= 20; k++) begin
      cyc();
      ea = 10'((k / 4) % 3);
      checks++;
      if (tick !== (k % 4 == 0) || done !== 1'b0 || addr !== ea || state !== 2'b01) begin
        errors++;
        $display("FAIL loop clk %0d: tick=%b done=%b addr=%0d state=%b, want tick=%b done=0 addr=%0d",
                 k, tick, done, addr, state, (k % 4 == 0), ea);
      end
    end
    // Single-step song: tick each step, address pinned at 0.
    do_reset();
    tempo_div = 16'd3; song_last = 10'd0; loop_en = 1;
    start_play();
    for (int k = 1; k <= 9; k++) begin
      cyc();
      checks++;
      if (tick !== (k % 3 == 0) || addr !== 10'd0 || state !== 2'b01) begin
        errors++;
        $display("FAIL loop_single clk %0d: tick=%b addr=%0d state=%b, want tick=%b addr=0",
                 k, tick, addr, state, (k % 3 == 0));
      end
    end
  endtask

  task automatic test_pause_resume();
    do_reset();
    tempo_div = 16'd10; song_last = 10'd5; loop_en = 0; mute = 3'b000;
    start_play();
    repeat (6) cyc();
    cmd_pause = 1;
    cyc();
    cmd_pause = 0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) cyc();
      checks++;
      if (state !== 2'b10 || voice_en !== 3'b000 || tick !== 1'b0 || addr !== 10'd0) begin
        errors++;
        $display("FAIL pause clk %0d: state=%b voice=%b tick=%b addr=%0d, want 10/000/0/0",
                 k, state, voice_en, tick, addr);
      end
    end
    cmd_play = 1;
    cyc();
    cmd_play = 0;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) cyc();
      checks++;
      if (state !== 2'b01 || tick !== (k == 4) || addr !== ((k == 4) ? 10'd1 : 10'd0)) begin
        errors++;
        $display("FAIL resume +%0d: state=%b tick=%b addr=%0d, want 01 tick=%b", k, state, tick, addr, (k == 4));
      end
    end
  endtask

  task automatic test_gating();
    logic [2:0] ev;
    do_reset();
    tempo_div = 16'd40; song_last = 10'd3; loop_en = 0; mute = 3'b010;
    start_play();
    for (int k = 0; k <= 42; k++) begin
      if (k > 0) cyc();
      ev = ((k % 40) >= GAP) ? 3'b101 : 3'b000;
      checks++;
      if (voice_en !== ev) begin
        errors++;
        $display("FAIL gating clk %0d: voice=%b, want %b", k, voice_en, ev);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    tempo_div = 16'd3; song_last = 10'd5; loop_en = 0; mute = 3'b000;
    start_play();
    repeat (5) cyc();
    // Boundary cycle: pause beats the step advance.
    cmd_pause = 1;
    cyc();
    cmd_pause = 0;
    checks++;
    if (state !== 2'b10 || addr !== 10'd1 || tick !== 1'b0) begin
      errors++;
      $display("FAIL boundary_pause: state=%b addr=%0d tick=%b, want 10/1/0", state, addr, tick);
    end
    cmd_play = 1;
    cyc();
    cmd_play = 0;
    // Resumed on the boundary; all three commands now arrive together.
    cmd_play = 1; cmd_pause = 1; cmd_stop = 1;
    cyc();
    cmd_play = 0; cmd_pause = 0; cmd_stop = 0;
    checks++;
    if (state !== 2'b00 || addr !== 10'd0 || tick !== 1'b0 || voice_en !== 3'b000) begin
      errors++;
      $display("FAIL simultaneous: state=%b addr=%0d tick=%b voice=%b, want 00/0/0/000",
               state, addr, tick, voice_en);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tempo_div = 16'd20; song_last = 10'd20; loop_en = 0; mute = 3'b000;
    start_play();
    repeat (117) cyc();
    checks++;
    if (addr !== 10'd5 || voice_en !== 3'b111 || state !== 2'b01) begin
      errors++;
      $display("FAIL pre_reset: addr=%0d voice=%b state=%b, want 5/111/01", addr, voice_en, state);
    end
    #2 rst = 1;
    #1;
    checks++;
    if (state !== 2'b00 || addr !== 10'd0 || voice_en !== 3'b000 || tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: state=%b addr=%0d voice=%b tick=%b, want 00/0/000/0",
               state, addr, voice_en, tick);
    end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    cyc();
    checks++;
    if (state !== 2'b00 || addr !== 10'd0) begin
      errors++;
      $display("FAIL idle_after_reset: state=%b addr=%0d, want 00/0", state, addr);
    end
    tempo_div = 16'd0;
    start_play();
    for (int k = 1; k <= 6; k++) begin
      cyc();
      checks++;
      if (tick !== 1'b1 || addr !== 10'(k) || state !== 2'b01) begin
        errors++;
        $display("FAIL tempo_zero clk %0d: tick=%b addr=%0d state=%b, want 1/%0d/01", k, tick, addr, state, k);
      end
    end
  endtask

  task automatic test_random();
    int r;
    logic [2:0] ev;
    do_reset();
    tempo_div = 16'd5; song_last = 10'd3; loop_en = 1; mute = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      cmd_stop  = (r < 2);
      cmd_pause = (r >= 2 && r < 5);
      cmd_play  = (r >= 5 && r < 13);
      if ($urandom_range(0, 19) == 0) tempo_div = 16'($urandom_range(0, 24));
      if ($urandom_range(0, 49) == 0) song_last = 10'($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0) loop_en = ~loop_en;
      if ($urandom_range(0, 29) == 0) mute = 3'($urandom_range(0, 7));
      cyc();
      ev = (m_mode == 1 && m_pos >= GAP) ? ~mute : 3'b000;
      checks++;
      if (state !== 2'(m_mode) || addr !== 10'(m_addr) || tick !== m_tick ||
          done !== m_done || voice_en !== ev) begin
        errors++;
        $display("FAIL random cyc %0d: state=%b addr=%0d tick=%b done=%b voice=%b, want %0d/%0d/%0d/%0d/%b",
                 i, state, addr, tick, done, voice_en, m_mode, m_addr, m_tick, m_done, ev);
      end
    end
    cmd_play = 0; cmd_pause = 0; cmd_stop = 0;
  endtask

  initial begin
    test_reset();
    test_basic_play();
    test_loop();
    test_pause_resume();
    test_gating();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 SHALL have parameter GAP_CYC, default 16, meaning the clocks at the start of each step during which voice gates are held low.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock, with all state updating on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port cmd_play, input, 1 bit: single-cycle start/resume request.
REQ-005 SHALL have port cmd_pause, input, 1 bit: single-cycle pause request.
REQ-006 SHALL have port cmd_stop, input, 1 bit: single-cycle stop request.
REQ-007 SHALL have port loop_en, input, 1 bit: level; wrap to the song start instead of finishing.
REQ-008 SHALL have port tempo_div, input, 16 bits: clocks per step.
REQ-009 SHALL have port song_last, input, 10 bits: address of the final step.
REQ-010 SHALL have port mute, input, 3 bits: per-voice mute.
REQ-011 SHALL have port addr, output, 10 bits: shared step address fed to all three voice tables.
REQ-012 SHALL have port voice_en, output, 3 bits: per-voice gate to the tone generators.
REQ-013 SHALL have port tick, output, 1 bit: one-cycle pulse, high in the cycle addr takes a new value.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at song end when loop_en is 0.
REQ-015 SHALL have port state, output, 2 bits: IDLE=00, PLAY=01, PAUSE=10, DONE=11.

Function
REQ-016 SHALL use a 4-state FSM (IDLE, PLAY, PAUSE, DONE) with registered outputs addr, tick, done and state.
REQ-017 SHALL resolve simultaneous commands by priority cmd_stop > cmd_pause > cmd_play, acting only on the highest-priority asserted command.
REQ-018 SHALL, in IDLE on cmd_play, enter PLAY with addr=0, div_cnt=0, and D latched from tempo_div.
REQ-019 SHALL, in PLAY on cmd_pause, enter PAUSE with addr, div_cnt and D frozen.
REQ-020 SHALL, in PAUSE on cmd_play, return to PLAY and resume from the frozen div_cnt, with no tick issued on resume.
REQ-021 SHALL, in PLAY, PAUSE or DONE on cmd_stop, enter IDLE with addr=0 and div_cnt=0.
REQ-022 SHALL, in DONE on cmd_play, enter PLAY exactly as from IDLE.
REQ-023 SHALL ignore cmd_pause in IDLE, PAUSE and DONE, and ignore cmd_play in PLAY.
REQ-024 SHALL, in PLAY, increment the 16-bit div_cnt each clock and, when div_cnt==D-1, on the next edge set div_cnt=0, relatch D from tempo_div and advance addr.
REQ-025 SHALL treat a latched tempo_div of 0 as 1, so a step always lasts at least 1 clock.
REQ-026 SHALL apply a tempo_div change only at the next step boundary, never mid-step.
REQ-027 SHALL advance addr as addr+1 when addr!=song_last.
REQ-028 SHALL, when addr==song_last and loop_en=1, wrap addr to 0, pulse tick, and stay in PLAY.
REQ-029 SHALL, when addr==song_last and loop_en=0, hold addr, enter DONE, pulse done for one cycle, and not pulse tick.
REQ-030 SHALL, when song_last=0 and loop_en=1, pulse tick every D clocks with addr remaining 0.
REQ-031 SHALL give a boundary-cycle cmd_stop or cmd_pause priority over the step advance, so no tick is issued and addr is not changed.
REQ-032 SHALL drive voice_en[i]=1 iff state==PLAY, mute[i]==0 and div_cnt>=GAP_CYC, as combinational logic from registers.
REQ-033 SHALL, when D<=GAP_CYC, keep voice_en at 0 throughout every step.

Reset
REQ-034 SHALL, on rst=1 at any time including mid-step or in PAUSE, immediately force state=IDLE, addr=0, div_cnt=0, D=1, tick=0, done=0 and voice_en=000.
REQ-035 SHALL, after rst deasserts, wait in IDLE for cmd_play.

Verification
REQ-036 SHALL pass basic play: tempo_div=4, song_last=2, loop_en=0, cmd_play pulse -> tick at clocks 4 and 8 with addr 1 then 2, done at clock 12, state=11, addr held at 2.
REQ-037 SHALL pass loop: same stimulus with loop_en=1 -> addr sequence 0,1,2,0,1, tick every 4 clocks, done never asserted.
REQ-038 SHALL pass pause/resume: tempo_div=10, cmd_pause at div_cnt=6 for 20 clocks, then cmd_play -> next tick exactly 4 clocks after resume, voice_en=000 throughout PAUSE.
REQ-039 SHALL pass gating: tempo_div=40, GAP_CYC=16, mute=010 -> voice_en=000 for div_cnt 0..15 and 101 for div_cnt 16..39.
REQ-040 SHALL pass simultaneous commands: cmd_stop, cmd_pause and cmd_play together in PLAY on a boundary cycle -> IDLE, addr=0, no tick.
REQ-041 SHALL pass reset mid-operation: rst pulse at addr=5 in PLAY -> IDLE, addr=0 and voice_en=000 before the next edge; tempo_div=0 then plays one step per clock.
